// File: rtl/mips_defs.sv
// Shared definitions for the fetch front end.
//   RESET_PC_DEF : default reset PC, which is also the base byte address of
//                  instruction memory
//   npc_op_e     : next-PC operation select
//   fetch_st_e   : instruction-memory port owner (fetch or debug read)
package mips_defs;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_op_e;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_DBG = 1'b1
  } fetch_st_e;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC computation. All arithmetic wraps modulo 2^32.
//   pc_i       : current PC
//   npc_op_i   : seq / branch / jump imm26 / jr
//   br_taken_i : branch condition, only used for branches
//   imm16_i    : branch offset in words (sign-extended)
//   imm26_i    : jump index
//   jr_addr_i  : register jump target
//   npc_o      : next PC
module npc_calc
  import mips_defs::*;
(
  input  logic [31:0] pc_i,
  input  logic [1:0]  npc_op_i,
  input  logic        br_taken_i,
  input  logic [15:0] imm16_i,
  input  logic [25:0] imm26_i,
  input  logic [31:0] jr_addr_i,
  output logic [31:0] npc_o
);

  logic [31:0] pc4;
  logic [31:0] br_off;

  assign pc4    = pc_i + 32'd4;
  assign br_off = {{14{imm16_i[15]}}, imm16_i, 2'b00};

  always_comb begin
    npc_o = pc4;
    unique case (npc_op_e'(npc_op_i))
      NPC_SEQ: npc_o = pc4;
      NPC_BR:  npc_o = br_taken_i ? pc4 + br_off : pc4;
      NPC_J:   npc_o = {pc4[31:28], imm26_i, 2'b00};
      NPC_JR:  npc_o = jr_addr_i;
      default: npc_o = pc4;
    endcase
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC register, next-PC selection and an
// arbiter sharing the instruction-memory port between fetch and a debug
// reader.
//   clk, reset          : clock, asynchronous active-high reset
//   stall               : hold PC, ignore redirect inputs
//   npc_op, br_taken,
//   imm16, imm26,
//   jr_addr             : next-PC controls
//   im_addr / im_instr  : IM byte offset (relative to RESET_PC) / read data
//   pc, pc_plus8        : current PC and link value
//   instr, instr_valid  : fetched word (0 when not valid)
//   addr_err            : PC misaligned or outside IM
//   dbg_req, dbg_addr   : debug read request (held until granted), address
//   dbg_gnt, dbg_data   : one-cycle grant and the word read in that cycle
module fetch_ctrl
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC      = RESET_PC_DEF,
  parameter int          IM_WORDS_LOG2 = 10,
  parameter int          DBG_MAX_WAIT  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_op,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] jr_addr,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus8,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        addr_err,
  input  logic        dbg_req,
  input  logic [31:0] dbg_addr,
  output logic        dbg_gnt,
  output logic [31:0] dbg_data
);

  localparam int          WW       = (DBG_MAX_WAIT > 0) ? $clog2(DBG_MAX_WAIT + 1) : 1;
  localparam logic [WW-1:0] WAIT_MAX = WW'(DBG_MAX_WAIT);
  localparam logic [31:0] IM_DEPTH = 32'd1 << IM_WORDS_LOG2;

  fetch_st_e     state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [31:0]   npc;
  logic [31:0]   pc_off;
  logic          go_dbg;

  npc_calc u_npc (
    .pc_i       (pc_q),
    .npc_op_i   (npc_op),
    .br_taken_i (br_taken),
    .imm16_i    (imm16),
    .imm26_i    (imm26),
    .jr_addr_i  (jr_addr),
    .npc_o      (npc)
  );

  assign pc_off = pc_q - RESET_PC;

  // Stall means fetch is not using the port this cycle, so a waiting
  // request is granted at once; otherwise it waits until the counter
  // saturates.
  assign go_dbg = (state_q == ST_RUN) && dbg_req && (stall || wait_q == WAIT_MAX);

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      ST_RUN: begin
        // The redirect still lands on the grant edge; the debug cycle
        // follows it.
        if (!stall) pc_d = npc;
        if (go_dbg) begin
          state_d = ST_DBG;
          wait_d  = '0;
        end else if (!dbg_req) begin
          wait_d = '0;
        end else if (!stall && wait_q != WAIT_MAX) begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_DBG: begin
        // Single debug cycle; the return to RUN guarantees a fetch slot
        // between back-to-back grants.
        state_d = ST_RUN;
        wait_d  = '0;
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wait_q  <= wait_d;
    end
  end

  // Outputs decode directly from state/PC so reset clears them without a
  // clock edge.
  assign addr_err    = (pc_q[1:0] != 2'b00) || ({2'b00, pc_off[31:2]} >= IM_DEPTH);
  assign im_addr     = (state_q == ST_DBG) ? dbg_addr - RESET_PC : pc_off;
  assign instr_valid = (state_q == ST_RUN) && !addr_err;
  assign instr       = instr_valid ? im_instr : 32'h0;
  assign dbg_gnt     = (state_q == ST_DBG);
  assign dbg_data    = im_instr;
  assign pc          = pc_q;
  assign pc_plus8    = pc_q + 32'd8;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: the driver pushes per-cycle expected
// outputs (and expected debug read data) computed by a behavioural model;
// a monitor pops and compares on the falling edge.
module tb_fetch_ctrl;

  localparam logic [31:0] RP = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_op;
  logic        br_taken;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] jr_addr;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic [31:0] pc;
  logic [31:0] pc_plus8;
  logic [31:0] instr;
  logic        instr_valid;
  logic        addr_err;
  logic        dbg_req;
  logic [31:0] dbg_addr;
  logic        dbg_gnt;
  logic [31:0] dbg_data;

  fetch_ctrl #(.RESET_PC(RP), .IM_WORDS_LOG2(10), .DBG_MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_op(npc_op),
    .br_taken(br_taken), .imm16(imm16), .imm26(imm26), .jr_addr(jr_addr),
    .im_addr(im_addr), .im_instr(im_instr), .pc(pc), .pc_plus8(pc_plus8),
    .instr(instr), .instr_valid(instr_valid), .addr_err(addr_err),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
    .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Instruction memory: 1024 random words, read combinationally.
  logic [31:0] im_mem [1024];
  assign im_instr = im_mem[im_addr[11:2]];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc8;
    logic [31:0] ima;
    logic [31:0] instr;
    logic        valid;
    logic        err;
    logic        gnt;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] gntq[$];
  int          tests = 0;
  int          fails = 0;

  // Reference model state
  logic [31:0] m_pc;
  bit          m_dbg;
  int          m_wait;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_err(input logic [31:0] a);
    logic [31:0] off;
    off = a - RP;
    return (a % 4 != 0) || (off / 4 >= 1024);
  endfunction

  function automatic logic [31:0] mem_at(input logic [31:0] a);
    logic [31:0] off;
    off = (a - RP) / 4;
    return im_mem[off % 1024];
  endfunction

  // One clock cycle: apply inputs, predict this cycle's outputs, then
  // advance the model across the edge.
  task automatic cyc(input logic [1:0] op, input logic bt, input logic [15:0] i16,
                     input logic [25:0] i26, input logic [31:0] jr,
                     input logic stl, input logic req, input logic [31:0] da);
    exp_t e;
    logic [31:0] nxt;
    npc_op = op; br_taken = bt; imm16 = i16; imm26 = i26; jr_addr = jr;
    stall = stl; dbg_req = req; dbg_addr = da;
    e.pc    = m_pc;
    e.pc8   = m_pc + 32'd8;
    e.gnt   = m_dbg;
    e.err   = in_err(m_pc);
    e.ima   = m_dbg ? da - RP : m_pc - RP;
    e.valid = !m_dbg && !e.err;
    e.instr = e.valid ? mem_at(m_pc) : 32'h0;
    expq.push_back(e);
    if (m_dbg) gntq.push_back(mem_at(da));
    @(posedge clk);
    if (m_dbg) begin
      m_dbg  = 0;
      m_wait = 0;
    end else begin
      if (!stl) begin
        case (op)
          2'd0: nxt = m_pc + 4;
          2'd1: nxt = bt ? m_pc + 4 + 32'($signed(i16)) * 4 : m_pc + 4;
          2'd2: begin nxt = m_pc + 4; nxt = (nxt & 32'hF000_0000) | (32'(i26) * 4); end
          default: nxt = jr;
        endcase
        m_pc = nxt;
      end
      if (req && (stl || m_wait == 4)) begin
        m_dbg  = 1;
        m_wait = 0;
      end else if (!req) m_wait = 0;
      else if (!stl && m_wait < 4) m_wait++;
    end
    #1;
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) cyc(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (dbg_gnt) begin
        if (gntq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_gnt: got 1 expected 0 at %0t", $time);
        end else chk("dbg_data", dbg_data, gntq.pop_front());
      end
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("pc", pc, e.pc);
        chk("pc_plus8", pc_plus8, e.pc8);
        chk("im_addr", im_addr, e.ima);
        chk("instr", instr, e.instr);
        chk("instr_valid", 32'(instr_valid), 32'(e.valid));
        chk("addr_err", 32'(addr_err), 32'(e.err));
        chk("dbg_gnt", 32'(dbg_gnt), 32'(e.gnt));
      end
    end
  end

  initial begin
    bit g;
    logic req;
    logic [31:0] da;
    int k;
    for (int i = 0; i < 1024; i++) im_mem[i] = $urandom;
    reset = 1'b1; stall = 0; npc_op = 0; br_taken = 0; imm16 = 0; imm26 = 0;
    jr_addr = 0; dbg_req = 0; dbg_addr = 0;
    #3;
    chk("rst_pc", pc, RP);
    chk("rst_gnt", 32'(dbg_gnt), 32'd0);
    chk("rst_err", 32'(addr_err), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    m_pc = RP; m_dbg = 0; m_wait = 0;

    // Sequential fetch 0x3000..0x300C, leaving pc at 0x3010
    seq(4);
    // Branch back taken, return to 0x3010, branch not taken
    cyc(2'd1, 1'b1, 16'hFFFC, 26'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(2'd3, 1'b0, 16'h0, 26'h0, 32'h3010, 1'b0, 1'b0, 32'h0);
    cyc(2'd1, 1'b0, 16'hFFFC, 26'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    seq(1);
    // Misaligned jr: error persists as pc advances
    cyc(2'd3, 1'b0, 16'h0, 26'h0, 32'h3002, 1'b0, 1'b0, 32'h0);
    seq(2);
    // Jump back into range
    cyc(2'd2, 1'b0, 16'h0, 26'(32'h3020 >> 2), 32'h0, 1'b0, 1'b0, 32'h0);

    // Held debug request without stall: forced after the wait limit
    for (int i = 0; i < 12; i++) begin
      g = m_dbg;
      cyc(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1, 32'h3100);
      if (g) break;
    end
    seq(2);

    // Stall plus held request: grant every other cycle
    for (int i = 0; i < 6; i++) cyc(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b1, 32'h3100);
    seq(1);

    // Reset while granted
    for (int i = 0; i < 4 && !m_dbg; i++)
      cyc(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b1, 32'h3040);
    #1;
    chk("gnt_before_rst", 32'(dbg_gnt), 32'd1);
    reset = 1'b1;
    #1;
    chk("gnt_async_rst", 32'(dbg_gnt), 32'd0);
    chk("pc_async_rst", pc, RP);
    @(posedge clk); #1;
    reset = 1'b0; dbg_req = 1'b0;
    m_pc = RP; m_dbg = 0; m_wait = 0;
    seq(2);

    // Randomized traffic
    req = 1'b0; da = RP;
    for (int n = 0; n < 500; n++) begin
      if (!req && $urandom_range(0, 3) == 0) begin
        req = 1'b1;
        da = RP + 4 * $urandom_range(0, 1023);
      end
      k = $urandom_range(0, 64) - 32;
      g = m_dbg;
      cyc(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 16'(k),
          26'((32'h3000 >> 2) + $urandom_range(0, 1100)),
          RP + $urandom_range(0, 4400), ($urandom_range(0, 3) == 0), req, da);
      if (g) req = 1'b0;
    end
    seq(3);

    for (int i = 0; i < 10 && (expq.size() > 0 || gntq.size() > 0); i++) @(negedge clk);
    #1;
    if (expq.size() > 0 || gntq.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain: got %0d pending expected 0", expq.size() + gntq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
